pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central stall/flush controller for the 5-stage pipeline; the source of every suspend/flush input on the
//  IF/ID, ID/EX, EX/MEM and MEM/WB stage registers and of the PC hold.
//  Detects RAW hazards in ID, branch redirects from EX and data-memory wait states in MEM.
//  Resolves them by priority and keeps a small FSM for memory-wait tracking, timeout and performance counters.
// PARAMETERS
//  MEM_TIMEOUT  16  max consecutive MEM_WAIT cycles before the fatal timeout state (range 2..65535)
//  CNT_W        16  width of the saturating performance counters
// PORTS
//  clk_i             in   1      clock, rising edge
//  rst_n_i           in   1      asynchronous active-low reset
//  id_rs1_i/id_rs2_i in   5      source register indices of the instruction in ID
//  id_rs1_used_i     in   1      ID instruction reads rs1
//  id_rs2_used_i     in   1      ID instruction reads rs2
//  ex_rd_i           in   5      destination index in EX
//  ex_reg_write_i    in   1      EX instruction writes rd
//  ex_mem_read_i     in   1      EX instruction is a load
//  mem_rd_i          in   5      destination index in MEM
//  mem_reg_write_i   in   1      MEM instruction writes rd
//  branch_taken_i    in   1      EX resolved a taken branch or jump (PC redirect this cycle)
//  mem_req_i         in   1      MEM stage has an active data-memory access
//  mem_ready_i       in   1      data memory completes the access this cycle
//  pc_hold_o         out  1      PC keeps its value
//  if_id_suspend_o   out  1      IF/ID register holds
//  if_id_flush_o     out  1      IF/ID register loads a bubble
//  id_ex_suspend_o   out  1      ID/EX register holds
//  id_ex_flush_o     out  1      ID/EX register loads a bubble
//  ex_mem_suspend_o  out  1      EX/MEM register holds
//  mem_wb_flush_o    out  1      MEM/WB register loads a bubble
//  mem_timeout_o     out  1      sticky fatal flag: memory exceeded MEM_TIMEOUT
//  state_o           out  2      FSM state: 0 RUN, 1 MEM_WAIT, 2 ERR
//  stall_cnt_o       out  CNT_W  cycles with pc_hold_o=1
//  flush_cnt_o       out  CNT_W  cycles with branch flush
// BEHAVIOUR
//  - Reset (async, rst_n_i=0)
//    - state=RUN; wait_cnt=0; mem_timeout_o=0; both counters 0.
//    - Comb outputs follow the inputs with state=RUN.
//  - All control outputs are combinational from inputs and state: zero latency, asserted in the same cycle as the cause.
//  - mem_busy = mem_req_i & ~mem_ready_i.
//  - raw = (id_rs1_used_i & id_rs1_i==X) | (id_rs2_used_i & id_rs2_i==X), against producer rd X.
//    - Index 0 never hazards.
//  - Priority, highest first:
//    1. ERR: pc_hold, if_id/id_ex/ex_mem_suspend = 1; all flushes 0.
//    2. mem_busy: pc_hold, if_id/id_ex/ex_mem_suspend, mem_wb_flush = 1; other flushes 0.
//    3. branch_taken_i: if_id_flush = id_ex_flush = 1; pc_hold = 0; load-use in ID is discarded.
//    4. data hazard: pc_hold = if_id_suspend = id_ex_flush = 1.
//    5. none: all outputs 0.
//  - A suspend and a flush for the same register are never asserted together.
//  - FSM
//    - RUN -> MEM_WAIT when mem_busy.
//    - MEM_WAIT -> RUN on mem_ready_i; the stall drops that same cycle.
//    - MEM_WAIT -> ERR when wait_cnt == MEM_TIMEOUT-1 and ~mem_ready_i.
//    - ERR is terminal until reset.
//  - wait_cnt
//    - Loads 1 on RUN->MEM_WAIT.
//    - Increments each MEM_WAIT cycle.
//    - Cleared on exit.
//  - mem_timeout_o = (state==ERR), registered.
//  - Counters saturate at all-ones (no wrap).
//    - stall_cnt_o += 1 per cycle with pc_hold_o.
//    - flush_cnt_o += 1 per cycle with priority-3 flush.
//  - Reset asserted mid-MEM_WAIT or in ERR returns to RUN immediately and clears all state.
// CONFIGURATION
//  PIPE_FORWARD_EN defined (forwarding network present):
//  - Data hazard = ex_mem_read_i & ex_rd_i!=0 & raw(ex_rd_i); load-use, 1 bubble.
//  PIPE_FORWARD_EN undefined:
//  - Data hazard = (ex_reg_write_i & ex_rd_i!=0 & raw(ex_rd_i)) | (mem_reg_write_i & mem_rd_i!=0 & raw(mem_rd_i)).
//  - WB is covered by a write-first register file.
// TESTING
//  1. Load x5 in EX, ID reads rs1=x5, FORWARD_EN -> 1 cycle pc_hold=if_id_suspend=id_ex_flush=1; stall_cnt 0->1.
//  2. Same with rd=x0 -> no stall; ALU write x6 in MEM, ID reads x6, no FORWARD_EN -> stall while in MEM.
//  3. branch_taken_i=1 together with load-use -> if_id_flush=id_ex_flush=1, pc_hold=0; flush_cnt +1.
//  4. mem_req_i=1, mem_ready_i=0 for 3 cycles, then 1 -> state 1 for 3 cycles, full freeze + mem_wb_flush, RUN on cycle 4.
//  5. MEM_TIMEOUT=4, mem_ready_i held 0 -> ERR after 4 wait cycles, mem_timeout_o=1 sticky; rst_n_i=0 clears it.
//  6. Force 2^CNT_W+5 stall cycles -> stall_cnt_o saturates at 16'hFFFF.

Source files
------------

// File: rtl/pipe_hazard_if.sv
// Pipeline <-> hazard controller signal bundle: stage hazard inputs and stage-register control outputs.
// master = pipeline datapath side, slave = pipe_hazard_ctrl.
interface pipe_hazard_if;
    logic [4:0] id_rs1_i;
    logic [4:0] id_rs2_i;
    logic       id_rs1_used_i;
    logic       id_rs2_used_i;
    logic [4:0] ex_rd_i;
    logic       ex_reg_write_i;
    logic       ex_mem_read_i;
    logic [4:0] mem_rd_i;
    logic       mem_reg_write_i;
    logic       branch_taken_i;
    logic       mem_req_i;
    logic       mem_ready_i;
    logic       pc_hold_o;
    logic       if_id_suspend_o;
    logic       if_id_flush_o;
    logic       id_ex_suspend_o;
    logic       id_ex_flush_o;
    logic       ex_mem_suspend_o;
    logic       mem_wb_flush_o;

    modport master (
        output id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
               ex_rd_i, ex_reg_write_i, ex_mem_read_i,
               mem_rd_i, mem_reg_write_i, branch_taken_i, mem_req_i, mem_ready_i,
        input  pc_hold_o, if_id_suspend_o, if_id_flush_o, id_ex_suspend_o,
               id_ex_flush_o, ex_mem_suspend_o, mem_wb_flush_o
    );

    modport slave (
        input  id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
               ex_rd_i, ex_reg_write_i, ex_mem_read_i,
               mem_rd_i, mem_reg_write_i, branch_taken_i, mem_req_i, mem_ready_i,
        output pc_hold_o, if_id_suspend_o, if_id_flush_o, id_ex_suspend_o,
               id_ex_flush_o, ex_mem_suspend_o, mem_wb_flush_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: RAW, branch redirect and data-memory wait handling.
// Optional macro PIPE_FORWARD_EN: forwarding network present, only load-use stalls.
//
// state       | meaning
// ST_RUN      | normal flow, combinational hazard resolution
// ST_MEM_WAIT | data memory access outstanding, wait_cnt counts wait cycles
// ST_ERR      | memory timeout, pipeline frozen until reset
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    pipe_hazard_if.slave     hz,
    output logic             mem_timeout_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } state_t;

    localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

    state_t      state_q, state_n;
    logic [15:0] wait_cnt_q, wait_cnt_n;
    logic        mem_busy;
    logic        raw_ex;
    logic        data_hazard;
    logic        branch_flush;
    logic        unused_ok;

    assign mem_busy = hz.mem_req_i & ~hz.mem_ready_i;
    assign raw_ex   = (hz.ex_rd_i != 5'd0) &
                      ((hz.id_rs1_used_i & (hz.id_rs1_i == hz.ex_rd_i)) |
                       (hz.id_rs2_used_i & (hz.id_rs2_i == hz.ex_rd_i)));

`ifdef PIPE_FORWARD_EN
    assign data_hazard = hz.ex_mem_read_i & raw_ex;
    assign unused_ok   = &{1'b0, hz.ex_reg_write_i, hz.mem_reg_write_i, hz.mem_rd_i};
`else
    logic raw_mem;
    // WB needs no check: the register file is write-first.
    assign raw_mem     = (hz.mem_rd_i != 5'd0) &
                         ((hz.id_rs1_used_i & (hz.id_rs1_i == hz.mem_rd_i)) |
                          (hz.id_rs2_used_i & (hz.id_rs2_i == hz.mem_rd_i)));
    assign data_hazard = (hz.ex_reg_write_i & raw_ex) | (hz.mem_reg_write_i & raw_mem);
    assign unused_ok   = &{1'b0, hz.ex_mem_read_i};
`endif

    always_comb begin
        hz.pc_hold_o        = 1'b0;
        hz.if_id_suspend_o  = 1'b0;
        hz.if_id_flush_o    = 1'b0;
        hz.id_ex_suspend_o  = 1'b0;
        hz.id_ex_flush_o    = 1'b0;
        hz.ex_mem_suspend_o = 1'b0;
        hz.mem_wb_flush_o   = 1'b0;
        branch_flush        = 1'b0;
        if (state_q == ST_ERR) begin
            hz.pc_hold_o        = 1'b1;
            hz.if_id_suspend_o  = 1'b1;
            hz.id_ex_suspend_o  = 1'b1;
            hz.ex_mem_suspend_o = 1'b1;
        end else if (mem_busy) begin
            hz.pc_hold_o        = 1'b1;
            hz.if_id_suspend_o  = 1'b1;
            hz.id_ex_suspend_o  = 1'b1;
            hz.ex_mem_suspend_o = 1'b1;
            hz.mem_wb_flush_o   = 1'b1;
        end else if (hz.branch_taken_i) begin
            // Redirect kills the ID instruction, so any load-use stall on it is moot.
            hz.if_id_flush_o = 1'b1;
            hz.id_ex_flush_o = 1'b1;
            branch_flush     = 1'b1;
        end else if (data_hazard) begin
            hz.pc_hold_o       = 1'b1;
            hz.if_id_suspend_o = 1'b1;
            hz.id_ex_flush_o   = 1'b1;
        end
    end

    always_comb begin
        state_n    = state_q;
        wait_cnt_n = wait_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (mem_busy) begin
                    state_n    = ST_MEM_WAIT;
                    wait_cnt_n = 16'd1;
                end
            end
            ST_MEM_WAIT: begin
                // Leaving on ~mem_busy also recovers if the request is withdrawn.
                if (!mem_busy) begin
                    state_n    = ST_RUN;
                    wait_cnt_n = 16'd0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_n    = ST_ERR;
                    wait_cnt_n = 16'd0;
                end else begin
                    wait_cnt_n = wait_cnt_q + 16'd1;
                end
            end
            ST_ERR:  state_n = ST_ERR;
            default: begin
                state_n    = ST_RUN;
                wait_cnt_n = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= 16'd0;
            mem_timeout_o <= 1'b0;
            stall_cnt_o   <= '0;
            flush_cnt_o   <= '0;
        end else begin
            state_q       <= state_n;
            wait_cnt_q    <= wait_cnt_n;
            mem_timeout_o <= (state_n == ST_ERR);
            if (hz.pc_hold_o && (stall_cnt_o != {CNT_W{1'b1}}))
                stall_cnt_o <= stall_cnt_o + 1'b1;
            if (branch_flush && (flush_cnt_o != {CNT_W{1'b1}}))
                flush_cnt_o <= flush_cnt_o + 1'b1;
        end
    end

    assign state_o = state_q;
endmodule
